// File: rtl/dram_arbiter.sv
// dram_arbiter: round-robin arbiter sharing one single-port data RAM between
// the CPU memory stage (master 0) and a secondary master (master 1).
// A burst counter bounds how long one master keeps the RAM while the other waits.
module dram_arbiter #(
   parameter int unsigned BURST_MAX = 4,
   parameter int unsigned AW        = 32,
   parameter int unsigned DW        = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [3:0]    m0_sel,
   input  logic [DW-1:0] m0_wdata,
   output logic [DW-1:0] m0_rdata,
   output logic          m0_ack,
   output logic          m0_stall,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_addr,
   input  logic [3:0]    m1_sel,
   input  logic [DW-1:0] m1_wdata,
   output logic [DW-1:0] m1_rdata,
   output logic          m1_ack,
   output logic          ram_ce,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [3:0]    ram_sel,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_OWN0 = 2'd1;
   localparam logic [1:0] S_OWN1 = 2'd2;
   localparam logic [3:0] C_BMAX = 4'(BURST_MAX);

   logic [1:0] r_state;
   logic [3:0] r_cnt;
   logic       r_last;

   logic       w_own1;
   logic       w_own_req;
   logic       w_oth_req;
   logic [1:0] w_oth_state;
   logic       w_g0;
   logic       w_g1;

   // Owner/other view of the requests so both OWN states share one path
   always_comb begin
      w_own1      = (r_state == S_OWN1);
      w_own_req   = w_own1 ? m1_req : m0_req;
      w_oth_req   = w_own1 ? m0_req : m1_req;
      w_oth_state = w_own1 ? S_OWN0 : S_OWN1;
   end

   // Ownership FSM, burst counter and last-owner tracking
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_last  <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               // on a tie the master that did not own last wins
               if (m0_req && (!m1_req || r_last)) begin
                  r_state <= S_OWN0;
                  r_cnt   <= 4'd1;
               end else if (m1_req) begin
                  r_state <= S_OWN1;
                  r_cnt   <= 4'd1;
               end
            end
            S_OWN0, S_OWN1: begin
               if (!w_own_req) begin
                  r_last <= w_own1;
                  if (w_oth_req) begin
                     r_state <= w_oth_state;
                     r_cnt   <= 4'd1;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end else if (!w_oth_req) begin
                  if (r_cnt < C_BMAX) r_cnt <= r_cnt + 4'd1;
               end else if (r_cnt < C_BMAX) begin
                  r_cnt <= r_cnt + 4'd1;
               end else begin
                  r_state <= w_oth_state;
                  r_cnt   <= 4'd1;
                  r_last  <= w_own1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   // RAM bus and acks decoded from owner; reset forces the bus idle at once
   // so a write pending in the reset cycle never reaches the RAM
   always_comb begin
      w_g0      = !rst && (r_state == S_OWN0);
      w_g1      = !rst && (r_state == S_OWN1);
      m0_ack    = w_g0 & m0_req;
      m1_ack    = w_g1 & m1_req;
      m0_stall  = m0_req & ~m0_ack;
      m0_rdata  = m0_ack ? ram_rdata : '0;
      m1_rdata  = m1_ack ? ram_rdata : '0;
      ram_ce    = m0_ack | m1_ack;
      ram_we    = (m0_ack & m0_we) | (m1_ack & m1_we);
      ram_addr  = w_g0 ? m0_addr  : (w_g1 ? m1_addr  : '0);
      ram_sel   = w_g0 ? m0_sel   : (w_g1 ? m1_sel   : '0);
      ram_wdata = w_g0 ? m0_wdata : (w_g1 ? m1_wdata : '0);
   end

endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: directed-vector bench for dram_arbiter (BURST_MAX=4).
module tb_dram_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_req, m0_we;
   logic [31:0] m0_addr, m0_wdata, m0_rdata;
   logic [3:0]  m0_sel;
   logic        m0_ack, m0_stall;
   logic        m1_req, m1_we;
   logic [31:0] m1_addr, m1_wdata, m1_rdata;
   logic [3:0]  m1_sel;
   logic        m1_ack;
   logic        ram_ce, ram_we;
   logic [31:0] ram_addr, ram_wdata, ram_rdata;
   logic [3:0]  ram_sel;

   int unsigned n_total = 0;
   int unsigned n_bad   = 0;

   dram_arbiter #(.BURST_MAX(4), .AW(32), .DW(32)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_sel(m0_sel),
      .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_stall(m0_stall),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_sel(m1_sel),
      .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ack(m1_ack),
      .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_sel(ram_sel),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // one clock edge, then settle past it before sampling
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      m0_req = 0; m0_we = 0; m0_addr = '0; m0_sel = '0; m0_wdata = '0;
      m1_req = 0; m1_we = 0; m1_addr = '0; m1_sel = '0; m1_wdata = '0;
      ram_rdata = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      #1;
   endtask

   // expected {m1_ack, m0_ack} for both masters holding req from IDLE
   logic [1:0] exp_pat [12];

   initial begin
      idle_inputs();
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
      // non-owner garbage must not reach the idle bus
      m1_addr = 32'hFFFF_FFFF; m1_wdata = 32'hA5A5_A5A5; m1_sel = 4'hF; m1_we = 1;
      #1;
      chk("rst_ce",    {31'd0, ram_ce}, 32'd0);
      chk("rst_we",    {31'd0, ram_we}, 32'd0);
      chk("rst_addr",  ram_addr, 32'd0);
      chk("rst_sel",   {28'd0, ram_sel}, 32'd0);
      chk("rst_wdata", ram_wdata, 32'd0);
      chk("rst_acks",  {30'd0, m1_ack, m0_ack}, 32'd0);

      // m0 single read
      do_reset();
      m0_req = 1; m0_addr = 32'h10; m0_sel = 4'hF; ram_rdata = 32'hDEAD_BEEF;
      #1;
      chk("rd_c1_stall", {31'd0, m0_stall}, 32'd1);
      chk("rd_c1_ack",   {31'd0, m0_ack}, 32'd0);
      chk("rd_c1_ce",    {31'd0, ram_ce}, 32'd0);
      cyc();
      chk("rd_c2_ack",   {31'd0, m0_ack}, 32'd1);
      chk("rd_c2_rdata", m0_rdata, 32'hDEAD_BEEF);
      chk("rd_c2_ce",    {31'd0, ram_ce}, 32'd1);
      chk("rd_c2_we",    {31'd0, ram_we}, 32'd0);
      chk("rd_c2_addr",  ram_addr, 32'h10);
      chk("rd_c2_stall", {31'd0, m0_stall}, 32'd0);
      chk("rd_c2_m1rd",  m1_rdata, 32'd0);

      // m1 single write
      do_reset();
      m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_sel = 4'b0011; m1_wdata = 32'h1234;
      #1;
      chk("wr_c1_ack", {31'd0, m1_ack}, 32'd0);
      cyc();
      chk("wr_we",    {31'd0, ram_we}, 32'd1);
      chk("wr_addr",  ram_addr, 32'h20);
      chk("wr_sel",   {28'd0, ram_sel}, 32'h3);
      chk("wr_wdata", ram_wdata, 32'h1234);
      chk("wr_m1ack", {31'd0, m1_ack}, 32'd1);
      chk("wr_m0ack", {31'd0, m0_ack}, 32'd0);

      // both hold req: m0 x4, m1 x4, m0 x4
      for (int unsigned i = 0; i < 12; i++)
         exp_pat[i] = (i >= 4 && i < 8) ? 2'b10 : 2'b01;
      do_reset();
      m0_req = 1; m0_addr = 32'h100; m1_req = 1; m1_addr = 32'h200;
      for (int unsigned i = 0; i < 12; i++) begin
         cyc();
         chk($sformatf("rr_ack%0d", i), {30'd0, m1_ack, m0_ack}, {30'd0, exp_pat[i]});
         chk($sformatf("rr_addr%0d", i), ram_addr, exp_pat[i][1] ? 32'h200 : 32'h100);
      end

      // m1 raises req at m0's cnt=2: two more m0 acks, then m1
      do_reset();
      m0_req = 1;
      cyc();
      chk("mid_c1", {30'd0, m1_ack, m0_ack}, 32'd1);
      cyc();
      chk("mid_c2", {30'd0, m1_ack, m0_ack}, 32'd1);
      m1_req = 1;
      cyc();
      chk("mid_c3", {30'd0, m1_ack, m0_ack}, 32'd1);
      cyc();
      chk("mid_c4", {30'd0, m1_ack, m0_ack}, 32'd1);
      cyc();
      chk("mid_c5", {30'd0, m1_ack, m0_ack}, 32'd2);

      // saturated counter: m1 arriving after a long m0 run waits one cycle
      do_reset();
      m0_req = 1;
      for (int unsigned i = 0; i < 6; i++) cyc();
      chk("sat_c6", {30'd0, m1_ack, m0_ack}, 32'd1);
      m1_req = 1;
      cyc();
      chk("sat_c7", {30'd0, m1_ack, m0_ack}, 32'd2);

      // m1 drops while m0 waits, then round-robin tie goes to m1
      do_reset();
      m1_req = 1;
      cyc();
      chk("drop_c1", {30'd0, m1_ack, m0_ack}, 32'd2);
      m0_req = 1;
      cyc();
      chk("drop_c2", {30'd0, m1_ack, m0_ack}, 32'd2);
      m1_req = 0; m1_we = 1;
      #1;
      chk("drop_noce", {31'd0, ram_ce}, 32'd0);
      chk("drop_nowe", {31'd0, ram_we}, 32'd0);
      cyc();
      chk("drop_c3", {30'd0, m1_ack, m0_ack}, 32'd1);
      m0_req = 0;
      cyc();
      chk("drop_idle", {30'd0, m1_ack, m0_ack}, 32'd0);
      m0_req = 1; m1_req = 1;
      cyc();
      chk("drop_tie", {30'd0, m1_ack, m0_ack}, 32'd2);

      // reset during an m1 write
      do_reset();
      m1_req = 1; m1_we = 1; m1_addr = 32'h40; m1_wdata = 32'h55;
      cyc();
      chk("rmid_own", {31'd0, ram_we}, 32'd1);
      rst = 1;
      #1;
      chk("rmid_rst_we", {31'd0, ram_we}, 32'd0);
      cyc();
      rst = 0;
      #1;
      chk("rmid_ce",   {31'd0, ram_ce}, 32'd0);
      chk("rmid_we",   {31'd0, ram_we}, 32'd0);
      chk("rmid_acks", {30'd0, m1_ack, m0_ack}, 32'd0);
      cyc();
      chk("rmid_regrant", {30'd0, m1_ack, m0_ack}, 32'd2);
      chk("rmid_rewe",    {31'd0, ram_we}, 32'd1);

      idle_inputs();
      cyc();
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
